ex_muldiv_ctrl: RTL
===================

// Module: ex_muldiv_ctrl
// PURPOSE
//  Multi-cycle RV32M sequencer in EX, beside the single-cycle ALU.
//  Accepts MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU plus operands from the EX bus.
//  Runs a radix-2 shift-add / restoring-divide loop, stalls the pipeline meanwhile,
//  then presents rd result for one cycle.
// PARAMETERS
//  XLEN   32             operand/result width; only 32 is supported
//  CNT_W  $clog2(XLEN)   iteration counter width
// PORTS
//  clk       in   1     clock
//  rst_n     in   1     reset (one clock; synchronous, active-low)
//  valid_i   in   1     EX holds an M-ext instruction; held until done_o
//  op_i      in   3     core::muldiv_op_t (= funct3)
//  rs1_i     in   32    forwarded rs1 data
//  rs2_i     in   32    forwarded rs2 data
//  rd_i      in   5     destination register
//  flush_i   in   1     branch/exception squash of EX
//  ready_o   out  1     state==IDLE
//  stall_o   out  1     valid_i & ~done_o; freezes IF/ID/EX
//  done_o    out  1     result valid, one-cycle pulse
//  result_o  out  32    rd value, registered, valid when done_o
//  rd_o      out  5     registered rd_i, valid when done_o
// BEHAVIOUR
//  Reset (rst_n=0 at an edge): state=IDLE, cnt=0, done_o=0, result_o=0, rd_o=0, ready_o=1.
//  Accept: valid_i & ready_o & ~flush_i at an edge; latch op, rd, operands.
//  FSM:
//    IDLE -> PREP on accept.
//    PREP: take abs() of signed operands (per op); record result sign.
//      Special cases go straight to DONE:
//        divisor==0: DIV/DIVU=32'hFFFF_FFFF; REM/REMU=rs1.
//        DIV 32'h8000_0000 / -1 = 32'h8000_0000; REM of same = 0.
//      Otherwise -> CALC, cnt=0.
//    CALC: one shift-add (mul, 64b acc) or restoring step (div) per cycle.
//      cnt++; after cnt==XLEN-1 -> FIX.
//    FIX: conditional 2's-complement negate.
//      Select lo (MUL), hi (MULH*), quotient, or remainder. -> DONE.
//    DONE: done_o=1, result_o/rd_o stable. -> IDLE unconditionally.
//  Latency (accept edge to done_o high): normal 34 cycles; special case 2 cycles.
//  Back-to-back M ops: one idle cycle between done_o and next accept.
//  Signedness: MULHSU treats rs1 signed, rs2 unsigned.
//    Remainder sign = dividend sign; quotient sign = XOR of signs.
//  flush_i in any state: next state IDLE, no done_o, datapath regs don't-care.
//    Wins over a same-cycle accept.
//  Reset mid-operation: identical to flush; no done_o.
//  Operand changes on rs1_i/rs2_i after accept are ignored.
//  valid_i dropping without flush while busy is illegal; assert in sim.
// STRUCTURE
//  core pkg: muldiv_op_t enum (MUL=0..REMU=7), MULDIV_LAT=34 localparam.
//  Local FSM enum {IDLE,PREP,CALC,FIX,DONE}.
//  Sub-module muldiv_step (combinational):
//    one iteration {acc,mq,opnd,is_div} -> {acc',mq'}.
//  Controller holds FSM, counter and registers.
// TESTING
//  MUL 7*-3 -> done_o 34 cycles after accept, result 32'hFFFF_FFEB; stall_o high 34 cycles.
//  MULH 32'h8000_0000*32'h8000_0000 -> 32'h4000_0000; MULHU FFFF_FFFF*FFFF_FFFF -> FFFF_FFFE.
//  DIV -7/2 -> FFFF_FFFD; REM -7/2 -> FFFF_FFFF; DIVU 100/7 -> 14; REMU -> 2.
//  DIV x/0 -> FFFF_FFFF, REMU 5/0 -> 5, DIV 8000_0000/-1 -> 8000_0000; each done_o 2 cycles after accept.
//  flush_i at CALC cnt=10 -> IDLE next cycle, no done_o; new op accepted next cycle, correct.
//  rst_n low at CALC -> outputs at reset values; valid_i+flush_i same cycle in IDLE -> not accepted.

Source files
------------

// File: rtl/ex_muldiv_ctrl_pkg.sv
// Shared types for the EX-stage RV32M sequencer: op encoding (= funct3) and
// operand-class helpers.
package ex_muldiv_ctrl_pkg;

  localparam int unsigned MULDIV_LAT = 34;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_t;

  function automatic logic op_is_div(input muldiv_op_t op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic op_is_rem(input muldiv_op_t op);
    return op inside {OP_REM, OP_REMU};
  endfunction

  function automatic logic op_signed_a(input muldiv_op_t op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic op_signed_b(input muldiv_op_t op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/ex_muldiv_ctrl_if.sv
// EX-bus bundle between the pipeline (master) and the M-extension sequencer (slave).
interface ex_muldiv_ctrl_if #(
  parameter int unsigned XLEN = 32
);
  import ex_muldiv_ctrl_pkg::*;

  logic            valid_i;
  muldiv_op_t      op_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic [4:0]      rd_i;
  logic            flush_i;
  logic            ready_o;
  logic            stall_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;
  logic [4:0]      rd_o;

  modport master (
    output valid_i, op_i, rs1_i, rs2_i, rd_i, flush_i,
    input  ready_o, stall_o, done_o, result_o, rd_o
  );

  modport slave (
    input  valid_i, op_i, rs1_i, rs2_i, rd_i, flush_i,
    output ready_o, stall_o, done_o, result_o, rd_o
  );

endinterface

// File: rtl/ex_muldiv_ctrl_step.sv
// One radix-2 iteration: LSB-first shift-add on {acc,mq} for multiply,
// restoring shift-subtract (quotient bits into mq LSB) for divide.
module muldiv_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] acc_i,
  input  logic [XLEN-1:0] mq_i,
  input  logic [XLEN-1:0] opnd_i,
  input  logic            is_div_i,
  output logic [XLEN-1:0] acc_o,
  output logic [XLEN-1:0] mq_o
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   rem_sh;
  logic [XLEN-1:0] diff;
  logic            ge;

  always_comb begin
    sum    = {1'b0, acc_i} + (mq_i[0] ? {1'b0, opnd_i} : '0);
    rem_sh = {acc_i, mq_i[XLEN-1]};
    ge     = (rem_sh >= {1'b0, opnd_i});
    // True difference is below opnd_i, so the modular 32-bit subtract is exact.
    diff   = rem_sh[XLEN-1:0] - opnd_i;
    if (is_div_i) begin
      acc_o = ge ? diff : rem_sh[XLEN-1:0];
      mq_o  = {mq_i[XLEN-2:0], ge};
    end else begin
      acc_o = sum[XLEN:1];
      mq_o  = {sum[0], mq_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// Multi-cycle RV32M sequencer beside the EX ALU: latches one M op, iterates
// 32 radix-2 steps, sign-fixes, and presents rd/result for one cycle.
module ex_muldiv_ctrl
  import ex_muldiv_ctrl_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = $clog2(XLEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  ex_muldiv_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  muldiv_op_t        op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]   mq_q, mq_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic              neg_q, neg_d;
  logic              spec_q, spec_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic [XLEN-1:0]   step_acc, step_mq;
  logic              a_sgn, b_sgn;
  logic [2*XLEN-1:0] prod, prod_n;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .acc_i    (acc_q),
    .mq_i     (mq_q),
    .opnd_i   (opnd_q),
    .is_div_i (op_is_div(op_q)),
    .acc_o    (step_acc),
    .mq_o     (step_mq)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= OP_MUL;
      rd_q     <= '0;
      acc_q    <= '0;
      mq_q     <= '0;
      opnd_q   <= '0;
      neg_q    <= 1'b0;
      spec_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      acc_q    <= acc_d;
      mq_q     <= mq_d;
      opnd_q   <= opnd_d;
      neg_q    <= neg_d;
      spec_q   <= spec_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    rd_d     = rd_q;
    acc_d    = acc_q;
    mq_d     = mq_q;
    opnd_d   = opnd_q;
    neg_d    = neg_q;
    spec_d   = spec_q;
    result_d = result_q;

    a_sgn  = op_signed_a(op_q) & mq_q[XLEN-1];
    b_sgn  = op_signed_b(op_q) & opnd_q[XLEN-1];
    prod   = {acc_q, mq_q};
    prod_n = neg_q ? -prod : prod;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.valid_i) begin
          state_d = ST_PREP;
          op_d    = bus.op_i;
          rd_d    = bus.rd_i;
          mq_d    = bus.rs1_i;
          opnd_d  = bus.rs2_i;
        end
      end
      ST_PREP: begin
        neg_d   = op_is_rem(op_q) ? a_sgn : (a_sgn ^ b_sgn);
        spec_d  = 1'b0;
        acc_d   = '0;
        mq_d    = a_sgn ? -mq_q : mq_q;
        opnd_d  = b_sgn ? -opnd_q : opnd_q;
        cnt_d   = '0;
        state_d = ST_CALC;
        // Special results park in acc and ride through FIX so result_q has a single load point.
        if (op_is_div(op_q) && opnd_q == '0) begin
          spec_d  = 1'b1;
          acc_d   = op_is_rem(op_q) ? mq_q : '1;
          state_d = ST_FIX;
        end else if (op_signed_a(op_q) && op_is_div(op_q) &&
                     mq_q == INT_MIN && opnd_q == '1) begin
          spec_d  = 1'b1;
          acc_d   = op_is_rem(op_q) ? '0 : INT_MIN;
          state_d = ST_FIX;
        end
      end
      ST_CALC: begin
        acc_d = step_acc;
        mq_d  = step_mq;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = ST_FIX;
      end
      ST_FIX: begin
        if (spec_q) begin
          result_d = acc_q;
        end else begin
          unique case (op_q)
            OP_MUL:                       result_d = prod_n[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result_d = prod_n[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              result_d = neg_q ? -mq_q : mq_q;
            default:                      result_d = neg_q ? -acc_q : acc_q;
          endcase
        end
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (bus.flush_i) state_d = ST_IDLE;
  end

  assign bus.ready_o  = (state_q == ST_IDLE);
  assign bus.done_o   = (state_q == ST_DONE);
  assign bus.stall_o  = bus.valid_i & ~bus.done_o;
  assign bus.result_o = result_q;
  assign bus.rd_o     = rd_q;

  a_valid_held: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q inside {ST_PREP, ST_CALC, ST_FIX} && !bus.flush_i) |-> bus.valid_i);

endmodule
